// File: rtl/wb_arbiter.sv
// wb_arbiter: NUM_CH producer channels, each with a private FIFO, feeding
// NUM_OUT writeback slots through a round-robin selector. flush_in discards
// everything buffered or arriving in the flush cycle.
// Optional macro WB_ARBITER_BYPASS_EN: an empty channel's incoming result may
// be granted in the same cycle and written straight into a slot register.
module wb_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int NUM_OUT = 2,
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 64,
   parameter int PTR_W   = 6,
   parameter int PREG_W  = 7
) (
   input  logic                               clk_in,
   input  logic                               rst_in,
   input  logic                               flush_in,
   input  logic [NUM_CH-1:0]                  ch_valid_in,
   output logic [NUM_CH-1:0]                  ch_ready_out,
   input  logic [NUM_CH*PTR_W-1:0]            ch_ptr_in,
   input  logic [NUM_CH*PREG_W-1:0]           ch_preg_in,
   input  logic [NUM_CH*DATA_W-1:0]           ch_data_in,
   output logic [NUM_OUT-1:0]                 wb_valid_out,
   output logic [NUM_OUT*PTR_W-1:0]           wb_ptr_out,
   output logic [NUM_OUT*PREG_W-1:0]          wb_preg_out,
   output logic [NUM_OUT*DATA_W-1:0]          wb_data_out,
   output logic [NUM_OUT*$clog2(NUM_CH)-1:0]  wb_ch_out
);

   localparam int CH_W  = $clog2(NUM_CH);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);
   localparam logic [CH_W:0]    NCH      = (CH_W + 1)'(NUM_CH);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

   typedef struct packed {
      logic [PTR_W-1:0]  ptr;
      logic [PREG_W-1:0] preg;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            mem_q    [NUM_CH][DEPTH];
   logic [AW-1:0]     head_q   [NUM_CH];
   logic [AW-1:0]     head_d   [NUM_CH];
   logic [AW-1:0]     tail_q   [NUM_CH];
   logic [AW-1:0]     tail_d   [NUM_CH];
   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CH_W-1:0]   rr_q, rr_d, rr_nxt_s;
   logic [NUM_OUT-1:0] wb_valid_q, wb_valid_d;
   entry_t            wb_ent_q [NUM_OUT];
   entry_t            wb_ent_d [NUM_OUT];
   logic [CH_W-1:0]   wb_ch_q  [NUM_OUT];
   logic [CH_W-1:0]   wb_ch_d  [NUM_OUT];

   entry_t            ch_ent_s [NUM_CH];
   logic [NUM_CH-1:0] elig_s, pop_s, byp_s, push_s;
   logic [NUM_OUT-1:0] sel_v_s;
   logic [CH_W-1:0]   sel_ch_s [NUM_OUT];
   logic [CH_W:0]     scan_idx_s;
   logic [CH_W-1:0]   scan_ch_s, last_ch_s;
   int                n_grant_s;

   // Unpack flat channel inputs; ready comes from the registered count only.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_ent_s[c].ptr  = ch_ptr_in[c*PTR_W +: PTR_W];
         ch_ent_s[c].preg = ch_preg_in[c*PREG_W +: PREG_W];
         ch_ent_s[c].data = ch_data_in[c*DATA_W +: DATA_W];
         ch_ready_out[c]  = (cnt_q[c] != FULL_CNT);
      end
   end

   // Pack the slot registers onto the flat writeback outputs.
   always_comb begin
      for (int s = 0; s < NUM_OUT; s++) begin
         wb_valid_out[s]                 = wb_valid_q[s];
         wb_ptr_out[s*PTR_W +: PTR_W]    = wb_ent_q[s].ptr;
         wb_preg_out[s*PREG_W +: PREG_W] = wb_ent_q[s].preg;
         wb_data_out[s*DATA_W +: DATA_W] = wb_ent_q[s].data;
         wb_ch_out[s*CH_W +: CH_W]       = wb_ch_q[s];
      end
   end

   // A channel may be granted when it holds an entry (or, with bypass, when it is presenting one).
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef WB_ARBITER_BYPASS_EN
         elig_s[c] = (cnt_q[c] != ZERO_CNT) || ch_valid_in[c];
`else
         elig_s[c] = (cnt_q[c] != ZERO_CNT);
`endif
      end
   end

   // Round-robin scan from rr_q: the first NUM_OUT eligible channels fill slots in scan order.
   always_comb begin
      pop_s      = {NUM_CH{1'b0}};
      byp_s      = {NUM_CH{1'b0}};
      sel_v_s    = {NUM_OUT{1'b0}};
      n_grant_s  = 0;
      last_ch_s  = rr_q;
      scan_idx_s = {(CH_W + 1){1'b0}};
      scan_ch_s  = {CH_W{1'b0}};
      for (int s = 0; s < NUM_OUT; s++) begin
         sel_ch_s[s] = {CH_W{1'b0}};
      end
      for (int i = 0; i < NUM_CH; i++) begin
         scan_idx_s = {1'b0, rr_q} + (CH_W + 1)'(i);
         if (scan_idx_s >= NCH) begin
            scan_idx_s = scan_idx_s - NCH;
         end else begin
            scan_idx_s = scan_idx_s;
         end
         scan_ch_s = scan_idx_s[CH_W-1:0];
         if (elig_s[scan_ch_s] && (n_grant_s < NUM_OUT)) begin
            for (int s = 0; s < NUM_OUT; s++) begin
               if (n_grant_s == s) begin
                  sel_v_s[s]  = 1'b1;
                  sel_ch_s[s] = scan_ch_s;
               end else begin
                  sel_ch_s[s] = sel_ch_s[s];
               end
            end
            if (cnt_q[scan_ch_s] != ZERO_CNT) begin
               pop_s[scan_ch_s] = 1'b1;
            end else begin
               byp_s[scan_ch_s] = 1'b1;
            end
            last_ch_s = scan_ch_s;
            n_grant_s = n_grant_s + 1;
         end else begin
            last_ch_s = last_ch_s;
         end
      end
      if (n_grant_s != 0) begin
         rr_nxt_s = (last_ch_s == LAST_CH) ? {CH_W{1'b0}} : last_ch_s + CH_W'(1);
      end else begin
         rr_nxt_s = rr_q;
      end
   end

   // Next state for FIFO pointers, counts, rr pointer and slot registers; flush overrides all.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         push_s[c] = ch_valid_in[c] && ch_ready_out[c] && !byp_s[c];
         tail_d[c] = push_s[c] ? tail_q[c] + AW'(1) : tail_q[c];
         head_d[c] = pop_s[c]  ? head_q[c] + AW'(1) : head_q[c];
         case ({push_s[c], pop_s[c]})
            2'b10:   cnt_d[c] = cnt_q[c] + CNT_W'(1);
            2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
            default: cnt_d[c] = cnt_q[c];
         endcase
      end
      rr_d       = rr_nxt_s;
      wb_valid_d = sel_v_s;
      for (int s = 0; s < NUM_OUT; s++) begin
         wb_ch_d[s] = sel_v_s[s] ? sel_ch_s[s] : wb_ch_q[s];
         if (!sel_v_s[s]) begin
            wb_ent_d[s] = wb_ent_q[s];
         end else if (cnt_q[sel_ch_s[s]] != ZERO_CNT) begin
            wb_ent_d[s] = mem_q[sel_ch_s[s]][head_q[sel_ch_s[s]]];
         end else begin
            wb_ent_d[s] = ch_ent_s[sel_ch_s[s]];
         end
      end
      if (flush_in) begin
         for (int c = 0; c < NUM_CH; c++) begin
            tail_d[c] = {AW{1'b0}};
            head_d[c] = {AW{1'b0}};
            cnt_d[c]  = ZERO_CNT;
         end
         rr_d       = {CH_W{1'b0}};
         wb_valid_d = {NUM_OUT{1'b0}};
         for (int s = 0; s < NUM_OUT; s++) begin
            wb_ent_d[s] = '0;
            wb_ch_d[s]  = {CH_W{1'b0}};
         end
      end else begin
         rr_d = rr_d;
      end
   end

   // Control and slot registers, cleared asynchronously by reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int c = 0; c < NUM_CH; c++) begin
            head_q[c] <= {AW{1'b0}};
            tail_q[c] <= {AW{1'b0}};
            cnt_q[c]  <= ZERO_CNT;
         end
         rr_q       <= {CH_W{1'b0}};
         wb_valid_q <= {NUM_OUT{1'b0}};
         for (int s = 0; s < NUM_OUT; s++) begin
            wb_ent_q[s] <= '0;
            wb_ch_q[s]  <= {CH_W{1'b0}};
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            head_q[c] <= head_d[c];
            tail_q[c] <= tail_d[c];
            cnt_q[c]  <= cnt_d[c];
         end
         rr_q       <= rr_d;
         wb_valid_q <= wb_valid_d;
         for (int s = 0; s < NUM_OUT; s++) begin
            wb_ent_q[s] <= wb_ent_d[s];
            wb_ch_q[s]  <= wb_ch_d[s];
         end
      end
   end

   // FIFO storage writes at the tail; no reset needed since count gates every read.
   always_ff @(posedge clk_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (push_s[c] && !flush_in && !rst_in) begin
            mem_q[c][tail_q[c]] <= ch_ent_s[c];
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (default parameters, bypass disabled): a directed
// vector table with hand-computed grants, an asynchronous reset sequence and
// a queue-based reference model for the saturation / wrap / flush phases.
module tb_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst, flush;
   logic [3:0]   ch_valid, ch_ready;
   logic [23:0]  ch_ptr;
   logic [27:0]  ch_preg;
   logic [255:0] ch_data;
   logic [1:0]   wb_valid;
   logic [11:0]  wb_ptr;
   logic [13:0]  wb_preg;
   logic [127:0] wb_data;
   logic [3:0]   wb_ch;

   int total = 0;
   int bad   = 0;

   wb_arbiter dut (
      .clk_in(clk), .rst_in(rst), .flush_in(flush),
      .ch_valid_in(ch_valid), .ch_ready_out(ch_ready),
      .ch_ptr_in(ch_ptr), .ch_preg_in(ch_preg), .ch_data_in(ch_data),
      .wb_valid_out(wb_valid), .wb_ptr_out(wb_ptr), .wb_preg_out(wb_preg),
      .wb_data_out(wb_data), .wb_ch_out(wb_ch)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] preg_of(input logic [5:0] p);
      return {1'b0, p} + 7'd12;
   endfunction

   function automatic logic [63:0] data_of(input logic [5:0] p);
      return 64'hDEA8 + {58'd0, p};
   endfunction

   function automatic logic [23:0] pk(input logic [5:0] p3, input logic [5:0] p2,
                                      input logic [5:0] p1, input logic [5:0] p0);
      return {p3, p2, p1, p0};
   endfunction

   task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [23:0] ptrs, input logic fl);
      ch_valid = v;
      flush    = fl;
      ch_ptr   = ptrs;
      for (int c = 0; c < 4; c++) begin
         ch_preg[c*7 +: 7]  = preg_of(ptrs[c*6 +: 6]);
         ch_data[c*64 +: 64] = data_of(ptrs[c*6 +: 6]);
      end
   endtask

   // compare one valid slot: {ptr, preg, data, ch}
   task automatic chk_slot(input string name, input int idx, input int s,
                           input logic [5:0] ep, input logic [1:0] ec);
      chk(name, idx,
          {49'd0, wb_ptr[s*6 +: 6], wb_preg[s*7 +: 7], wb_data[s*64 +: 64], wb_ch[s*2 +: 2]},
          {49'd0, ep, preg_of(ep), data_of(ep), ec});
   endtask

   typedef struct packed {
      logic [3:0]  v;
      logic [23:0] ptrs;
      logic        fl;
      logic [1:0]  ev;
      logic [5:0]  ep0;
      logic [1:0]  ec0;
      logic [5:0]  ep1;
      logic [1:0]  ec1;
      logic [3:0]  erdy;
   } vec_t;

   vec_t tbl [15];

   // reference model state
   logic [5:0] mq [4][$];
   int         mrr;
   int         full_seen;

   task automatic model_cycle(input int idx, input logic [3:0] v, input logic [23:0] ptrs, input logic fl);
      logic [1:0] ev;
      logic [5:0] ep [2];
      logic [1:0] ec [2];
      logic [3:0] erdy;
      bit         pre_rdy [4];
      int         n, last, c;
      drive(v, ptrs, fl);
      n = 0; ev = 2'b00; last = mrr;
      ep[0] = 6'd0; ep[1] = 6'd0; ec[0] = 2'd0; ec[1] = 2'd0;
      for (int k = 0; k < 4; k++) pre_rdy[k] = (mq[k].size() < 4);
      for (int i = 0; i < 4; i++) begin
         c = (mrr + i) % 4;
         if (mq[c].size() > 0 && n < 2) begin
            ev[n] = 1'b1;
            ep[n] = mq[c].pop_front();
            ec[n] = 2'(c);
            last  = c;
            n++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (v[k] && pre_rdy[k]) mq[k].push_back(ptrs[k*6 +: 6]);
      end
      if (n > 0) mrr = (last + 1) % 4;
      if (fl) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
         mrr = 0;
         ev  = 2'b00;
      end
      for (int k = 0; k < 4; k++) erdy[k] = (mq[k].size() < 4);
      @(posedge clk); #1;
      chk("m_valid", idx, {126'd0, wb_valid}, {126'd0, ev});
      chk("m_ready", idx, {124'd0, ch_ready}, {124'd0, erdy});
      if (ch_ready[0] == 1'b0) full_seen++;
      for (int s = 0; s < 2; s++) begin
         if (ev[s]) chk_slot("m_slot", idx, s, ep[s], ec[s]);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(4'b0000, 24'd0, 1'b0);
      // directed table: inputs applied before an edge, outputs checked just after it
      tbl[0]  = '{4'b0100, pk(0, 5, 0, 0),     1'b0, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};
      tbl[1]  = '{4'b0000, 24'd0,              1'b0, 2'b01, 6'd5,  2'd2, 6'd0,  2'd0, 4'hF};
      tbl[2]  = '{4'b0000, 24'd0,              1'b0, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};
      tbl[3]  = '{4'b1111, pk(13, 12, 11, 10), 1'b0, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};
      tbl[4]  = '{4'b1111, pk(23, 22, 21, 20), 1'b0, 2'b11, 6'd13, 2'd3, 6'd10, 2'd0, 4'hF};
      tbl[5]  = '{4'b0000, 24'd0,              1'b0, 2'b11, 6'd11, 2'd1, 6'd12, 2'd2, 4'hF};
      tbl[6]  = '{4'b0000, 24'd0,              1'b0, 2'b11, 6'd23, 2'd3, 6'd20, 2'd0, 4'hF};
      tbl[7]  = '{4'b0000, 24'd0,              1'b0, 2'b11, 6'd21, 2'd1, 6'd22, 2'd2, 4'hF};
      tbl[8]  = '{4'b1011, pk(33, 0, 31, 30),  1'b0, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};
      tbl[9]  = '{4'b1011, pk(37, 0, 35, 34),  1'b0, 2'b11, 6'd33, 2'd3, 6'd30, 2'd0, 4'hF};
      tbl[10] = '{4'b0100, pk(0, 50, 0, 0),    1'b1, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};
      tbl[11] = '{4'b0000, 24'd0,              1'b0, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};
      tbl[12] = '{4'b1001, pk(61, 0, 0, 60),   1'b0, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};
      tbl[13] = '{4'b0000, 24'd0,              1'b0, 2'b11, 6'd60, 2'd0, 6'd61, 2'd3, 4'hF};
      tbl[14] = '{4'b0000, 24'd0,              1'b0, 2'b00, 6'd0,  2'd0, 6'd0,  2'd0, 4'hF};

      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_valid", 0, {126'd0, wb_valid}, 128'd0);
      chk("rst_ready", 0, {124'd0, ch_ready}, {124'd0, 4'hF});
      chk("rst_data", 0, {wb_ptr, wb_preg, wb_data[99:0], wb_ch}, 128'd0);
      rst = 1'b0;

      for (int k = 0; k < 15; k++) begin
         drive(tbl[k].v, tbl[k].ptrs, tbl[k].fl);
         @(posedge clk); #1;
         chk("t_valid", k, {126'd0, wb_valid}, {126'd0, tbl[k].ev});
         chk("t_ready", k, {124'd0, ch_ready}, {124'd0, tbl[k].erdy});
         if (tbl[k].ev[0]) chk_slot("t_slot0", k, 0, tbl[k].ep0, tbl[k].ec0);
         if (tbl[k].ev[1]) chk_slot("t_slot1", k, 1, tbl[k].ep1, tbl[k].ec1);
      end

      // asynchronous reset between edges while results are in flight
      drive(4'b1111, pk(43, 42, 41, 40), 1'b0);
      @(posedge clk); #1;
      drive(4'b0000, 24'd0, 1'b0);
      @(posedge clk); #1;
      chk("pre_rst_valid", 0, {126'd0, wb_valid}, {126'd0, 2'b11});
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 0, {126'd0, wb_valid}, 128'd0);
      chk("arst_ready", 0, {124'd0, ch_ready}, {124'd0, 4'hF});
      chk("arst_data", 0, {wb_ptr, wb_preg, wb_data[99:0], wb_ch}, 128'd0);
      drive(4'b1111, pk(9, 9, 9, 9), 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(4'b1000, pk(62, 0, 0, 0), 1'b0);
      @(posedge clk); #1;
      chk("post_rst_v0", 0, {126'd0, wb_valid}, 128'd0);
      drive(4'b0000, 24'd0, 1'b0);
      @(posedge clk); #1;
      chk("post_rst_v1", 0, {126'd0, wb_valid}, {126'd0, 2'b01});
      chk_slot("post_rst_slot", 0, 0, 6'd62, 2'd3);
      @(posedge clk); #1;
      chk("post_rst_v2", 0, {126'd0, wb_valid}, 128'd0);

      // reference-model phases: saturation, random traffic with a flush, drain
      mrr = 0;
      full_seen = 0;
      for (int k = 0; k < 16; k++) begin
         logic [3:0] kk;
         kk = 4'(k);
         model_cycle(k, 4'hF, pk({2'd3, kk}, {2'd2, kk}, {2'd1, kk}, {2'd0, kk}), 1'b0);
      end
      chk("full_seen", 0, {127'd0, full_seen != 0}, {127'd0, 1'b1});
      for (int k = 0; k < 30; k++) begin
         logic [3:0] rv;
         logic [5:0] b;
         rv = 4'($urandom_range(0, 15));
         b  = 6'($urandom_range(0, 63));
         model_cycle(100 + k, rv, pk(b + 6'd3, b + 6'd2, b + 6'd1, b), k == 20);
      end
      for (int k = 0; k < 10; k++) begin
         model_cycle(200 + k, 4'b0010, pk(0, 0, 6'(k), 0), 1'b0);
      end
      for (int k = 0; k < 8; k++) begin
         model_cycle(300 + k, 4'b0000, 24'd0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
